// File: rtl/busarb2_pkg.sv
// Shared bus definitions for the two-master arbiter: state encoding,
// error data returned on a watchdog timeout, and the request helper.
package busarb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2,
        TOUT = 2'd3
    } state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

    function automatic logic bus_req(input logic we, input logic rd);
        return we | rd;
    endfunction

endpackage

// File: rtl/busarb2_pick.sv
// Combinational winner selection between two requesters.
// win = 0 selects master 0, win = 1 selects master 1; valid only when any = 1.
module busarb_pick #(
    parameter int unsigned RR = 1
) (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic win
);

    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            win = (RR != 0) ? ~last : 1'b0;
        end else begin
            win = req1;
        end
    end

endmodule

// File: rtl/busarb2.sv
// Two-master bus arbiter with registered grant, combinational data path
// and a watchdog that forces completion with error data on a stalled slave.
module busarb2
    import busarb2_pkg::*;
#(
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CW      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic        to_pulse,
    output logic [31:0] to_addr
);

    localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic          last, last_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          to_load;
    logic          req0, req1, own_req, to_hit;
    logic          p_req0, p_req1, pick_any, pick_win;

    assign req0 = bus_req(m0_we, m0_rd);
    assign req1 = bus_req(m1_we, m1_rd);

    // Outside IDLE, last always names the grant owner (it is rewritten on
    // every grant entry), so masking the owner leaves only the other master.
    assign own_req = last ? req1 : req0;
    assign p_req0  = (state == IDLE) ? req0 : (req0 & last);
    assign p_req1  = (state == IDLE) ? req1 : (req1 & ~last);
    assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);

    busarb_pick #(.RR(RR)) u_pick (
        .req0 (p_req0),
        .req1 (p_req1),
        .last (last),
        .any  (pick_any),
        .win  (pick_win)
    );

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = '0;
        to_load  = 1'b0;
        s_a      = '0;
        s_d      = '0;
        s_we     = 1'b0;
        s_rd     = 1'b0;
        m0_spo   = '0;
        m1_spo   = '0;
        m0_ready = ~req0;
        m1_ready = ~req1;
        to_pulse = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = pick_win ? G1 : G0;
                    last_nx  = pick_win;
                end
            end
            G0, G1: begin
                if (last) begin
                    s_a = m1_a; s_d = m1_d; s_we = m1_we; s_rd = m1_rd;
                    m1_spo   = s_spo;
                    m1_ready = s_ready;
                end else begin
                    s_a = m0_a; s_d = m0_d; s_we = m0_we; s_rd = m0_rd;
                    m0_spo   = s_spo;
                    m0_ready = s_ready;
                end
                if (!own_req) begin
                    state_nx = IDLE;
                end else if (s_ready) begin
                    if (pick_any) begin
                        state_nx = pick_win ? G1 : G0;
                        last_nx  = pick_win;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (to_hit) begin
                    state_nx = TOUT;
                    to_load  = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            TOUT: begin
                to_pulse = 1'b1;
                if (last) begin
                    m1_ready = 1'b1;
                    m1_spo   = BUS_ERR_DATA;
                end else begin
                    m0_ready = 1'b1;
                    m0_spo   = BUS_ERR_DATA;
                end
                if (pick_any) begin
                    state_nx = pick_win ? G1 : G0;
                    last_nx  = pick_win;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            to_addr <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
            if (to_load) to_addr <= s_a;
        end
    end

endmodule

// File: tb/tb_busarb2.sv
// Self-checking bench for busarb2: a round-robin and a fixed-priority
// instance share stimulus; expected values are queued and drained each cycle.
module tb_busarb2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_a, m0_d, m1_a, m1_d, s_spo;
    logic        m0_we, m0_rd, m1_we, m1_rd, s_ready;

    logic [31:0] m0_spo, m1_spo, s_a, s_d, to_addr;
    logic        m0_ready, m1_ready, s_we, s_rd, to_pulse;
    logic [31:0] fp_m0_spo, fp_m1_spo, fp_s_a, fp_s_d, fp_to_addr;
    logic        fp_m0_ready, fp_m1_ready, fp_s_we, fp_s_rd, fp_to_pulse;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    busarb2 #(.RR(1), .TIMEOUT(8), .CW(16)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
        .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
        .m1_spo(m1_spo), .m1_ready(m1_ready),
        .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
        .s_spo(s_spo), .s_ready(s_ready),
        .to_pulse(to_pulse), .to_addr(to_addr)
    );

    busarb2 #(.RR(0), .TIMEOUT(8), .CW(16)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
        .m0_spo(fp_m0_spo), .m0_ready(fp_m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
        .m1_spo(fp_m1_spo), .m1_ready(fp_m1_ready),
        .s_a(fp_s_a), .s_d(fp_s_d), .s_we(fp_s_we), .s_rd(fp_s_rd),
        .s_spo(s_spo), .s_ready(s_ready),
        .to_pulse(fp_to_pulse), .to_addr(fp_to_addr)
    );

    function automatic logic [31:0] obs(input string tag);
        case (tag)
            "s_a":         return s_a;
            "s_d":         return s_d;
            "s_we":        return {31'b0, s_we};
            "s_rd":        return {31'b0, s_rd};
            "m0_spo":      return m0_spo;
            "m0_ready":    return {31'b0, m0_ready};
            "m1_spo":      return m1_spo;
            "m1_ready":    return {31'b0, m1_ready};
            "to_pulse":    return {31'b0, to_pulse};
            "to_addr":     return to_addr;
            "fp_s_a":      return fp_s_a;
            "fp_s_rd":     return {31'b0, fp_s_rd};
            "fp_m0_ready": return {31'b0, fp_m0_ready};
            "fp_m1_ready": return {31'b0, fp_m1_ready};
            "fp_to_pulse": return {31'b0, fp_to_pulse};
            default:       return 'x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.tag), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_a = '0; m0_d = '0; m0_we = 1'b0; m0_rd = 1'b0;
        m1_a = '0; m1_d = '0; m1_we = 1'b0; m1_rd = 1'b0;
        s_spo = '0; s_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        expect_val("s_a", 32'h0);
        expect_val("s_we", 32'h0);
        expect_val("s_rd", 32'h0);
        expect_val("m0_ready", 32'h1);
        expect_val("m1_ready", 32'h1);
        expect_val("m0_spo", 32'h0);
        expect_val("to_pulse", 32'h0);
        expect_val("to_addr", 32'h0);
        drain();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single read, zero-wait slave
        m0_rd = 1'b1; m0_a = 32'h0000_1000; s_ready = 1'b1; s_spo = 32'h1234_5678;
        expect_val("s_rd", 32'h0);
        expect_val("m0_ready", 32'h0);
        drain();
        tick();
        expect_val("s_rd", 32'h1);
        expect_val("s_a", 32'h0000_1000);
        expect_val("m0_spo", 32'h1234_5678);
        expect_val("m0_ready", 32'h1);
        drain();
        tick();
        m0_rd = 1'b0; s_ready = 1'b0; s_spo = '0;
        expect_val("s_rd", 32'h0);
        expect_val("s_a", 32'h0);
        expect_val("m0_ready", 32'h1);
        drain();

        // simultaneous requests from reset: m0 first, direct handover to m1
        do_reset();
        m0_rd = 1'b1; m0_a = 32'h100; m1_rd = 1'b1; m1_a = 32'h200;
        expect_val("m0_ready", 32'h0);
        expect_val("m1_ready", 32'h0);
        drain();
        tick();
        expect_val("s_a", 32'h100);
        expect_val("m1_ready", 32'h0);
        expect_val("fp_s_a", 32'h100);
        drain();
        s_ready = 1'b1; s_spo = 32'hAA;
        expect_val("m0_ready", 32'h1);
        expect_val("m0_spo", 32'hAA);
        drain();
        tick();
        m0_rd = 1'b0;
        expect_val("s_a", 32'h200);
        expect_val("m1_spo", 32'hAA);
        expect_val("m1_ready", 32'h1);
        expect_val("m0_ready", 32'h1);
        expect_val("fp_s_a", 32'h200);
        drain();
        tick();
        m1_rd = 1'b0; s_ready = 1'b0;
        expect_val("s_rd", 32'h0);
        expect_val("s_a", 32'h0);
        drain();

        // continuous requests: grants alternate in both modes
        m0_rd = 1'b1; m1_rd = 1'b1; s_ready = 1'b1; s_spo = 32'h55;
        expect_val("fp_s_a", 32'h0);
        drain();
        tick();
        expect_val("fp_s_a", 32'h100);
        expect_val("fp_m1_ready", 32'h0);
        expect_val("s_a", 32'h100);
        drain();
        tick();
        expect_val("fp_s_a", 32'h200);
        expect_val("fp_m0_ready", 32'h0);
        expect_val("s_a", 32'h200);
        drain();
        tick();
        expect_val("fp_s_a", 32'h100);
        expect_val("fp_m1_ready", 32'h0);
        drain();
        m1_rd = 1'b0;
        tick();
        m0_rd = 1'b0;
        expect_val("fp_s_a", 32'h0);
        expect_val("s_a", 32'h0);
        drain();
        tick();
        m0_rd = 1'b1; m1_rd = 1'b1;
        expect_val("s_rd", 32'h0);
        drain();
        tick();
        // last = m0 now: round-robin favours m1, fixed priority keeps m0
        expect_val("s_a", 32'h200);
        expect_val("fp_s_a", 32'h100);
        drain();
        m0_rd = 1'b0; m1_rd = 1'b0;
        tick();
        s_ready = 1'b0;
        expect_val("s_rd", 32'h0);
        expect_val("fp_s_rd", 32'h0);
        drain();

        // abort while stalled
        m0_rd = 1'b1; m0_a = 32'h300;
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_val("to_pulse", 32'h0);
            expect_val("s_rd", 32'h1);
            drain();
            tick();
        end
        m0_rd = 1'b0;
        tick();
        expect_val("s_a", 32'h0);
        expect_val("to_pulse", 32'h0);
        drain();

        // timeout on a stalled m1 write
        m1_we = 1'b1; m1_a = 32'hF000_0004; m1_d = 32'h1234;
        tick();
        for (int k = 0; k < 8; k++) begin
            expect_val("to_pulse", 32'h0);
            expect_val("s_we", 32'h1);
            expect_val("s_a", 32'hF000_0004);
            drain();
            tick();
        end
        expect_val("to_pulse", 32'h1);
        expect_val("fp_to_pulse", 32'h1);
        expect_val("m1_ready", 32'h1);
        expect_val("m1_spo", 32'hFFFF_FFFF);
        expect_val("s_we", 32'h0);
        expect_val("to_addr", 32'hF000_0004);
        drain();
        tick();
        m1_we = 1'b0;
        expect_val("to_pulse", 32'h0);
        expect_val("s_we", 32'h0);
        expect_val("to_addr", 32'hF000_0004);
        drain();

        // slave answers on the last counted cycle: normal completion
        m0_rd = 1'b1; m0_a = 32'h400;
        tick();
        for (int k = 0; k < 7; k++) begin
            expect_val("to_pulse", 32'h0);
            drain();
            tick();
        end
        s_ready = 1'b1; s_spo = 32'h77;
        expect_val("m0_ready", 32'h1);
        expect_val("m0_spo", 32'h77);
        drain();
        tick();
        m0_rd = 1'b0; s_ready = 1'b0;
        expect_val("to_pulse", 32'h0);
        expect_val("m0_spo", 32'h0);
        expect_val("s_a", 32'h0);
        expect_val("to_addr", 32'hF000_0004);
        drain();

        // asynchronous reset in the middle of an m1 read
        m1_rd = 1'b1; m1_a = 32'h500;
        tick();
        expect_val("s_rd", 32'h1);
        expect_val("s_a", 32'h500);
        drain();
        rst_n = 1'b0;
        expect_val("s_rd", 32'h0);
        expect_val("s_a", 32'h0);
        expect_val("m1_ready", 32'h0);
        expect_val("to_addr", 32'h0);
        drain();
        tick(); tick();
        rst_n = 1'b1;
        m1_rd = 1'b0;
        tick();
        m0_rd = 1'b1; m0_a = 32'h600; m1_rd = 1'b1;
        tick();
        expect_val("s_a", 32'h600);
        expect_val("fp_s_a", 32'h600);
        drain();
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
